// File: rtl/div_restoring_ctrl.sv
// Restoring-division sequencer: owns A (partial remainder), Q (dividend/
// quotient) and M (divisor) and walks SHIFT, SUB, CHECK once per quotient bit.
// Ports: clk, rst (sync, active-high); start/dividend/divisor request;
// busy/done handshake; quotient/remainder/div_by_zero results (held);
// shift_en/sub_en/restore_en per-step strobes for the datapath.
module div_restoring_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             shift_en,
  output logic             sub_en,
  output logic             restore_en
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_SUB   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   m_ext;

  assign m_ext = {1'b0, m_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // Divide-by-zero finishes immediately with a fixed result.
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            a_d     = '0;
            q_d     = dividend;
            m_d     = divisor;
            cnt_d   = CW'(WIDTH - 1);
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        a_d     = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        q_d     = {q_q[WIDTH-2:0], 1'b0};
        state_d = S_SUB;
      end
      S_SUB: begin
        a_d     = a_q - m_ext;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // Sign bit set means the trial subtraction went negative.
        if (a_q[WIDTH]) begin
          a_d = a_q + m_ext;
        end else begin
          q_d[0] = 1'b1;
        end
        if (cnt_q == '0) begin
          quo_d   = q_d;
          rem_d   = a_d[WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign shift_en    = (state_q == S_SHIFT);
  assign sub_en      = (state_q == S_SUB);
  assign restore_en  = (state_q == S_CHECK) && a_q[WIDTH];
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_restoring_ctrl.sv
// Scoreboard bench for div_restoring_ctrl (WIDTH=4), directed vectors.
// Stimulus pushes expected results; a negedge monitor pops on done.
module tb_div_restoring_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;
  logic       shift_en, sub_en, restore_en;

  div_restoring_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero),
    .shift_en(shift_en), .sub_en(sub_en),
    .restore_en(restore_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    logic [3:0] mask;
    int         nchk;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   miss = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: tracks restore_en in each CHECK cycle (the cycle after sub_en)
  logic [3:0] rmask = '0;
  int         nchk = 0;
  logic       prev_sub = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      rmask = '0;
      nchk = 0;
      prev_sub = 1'b0;
    end else begin
      if (int'(shift_en) + int'(sub_en) + int'(restore_en) > 1) begin
        miss++;
        $display("FAIL strobes: not exclusive at cycle %0d", cyc);
      end
      if (prev_sub) begin
        rmask = {rmask[2:0], restore_en};
        nchk++;
      end
      prev_sub = sub_en;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", div_by_zero, e.dbz);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_in_done", busy, 1);
          chk("check_count", nchk, e.nchk);
          if (e.nchk != 0) chk("restore_mask", rmask, e.mask);
        end
        rmask = '0;
        nchk = 0;
      end
    end
  end

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic push(input logic [3:0] q, input logic [3:0] r,
                      input logic dbz, input logic [3:0] mask,
                      input int nc, input int dc);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz;
    e.mask = mask; e.nchk = nc; e.cyc = dc;
    sb.push_back(e);
  endtask

  // Issue one op from IDLE; returns cycle count right after accept edge.
  task automatic issue(input logic [3:0] dd, input logic [3:0] dv,
                       output int c0);
    @(negedge clk);
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
  endtask

  task automatic run(input string nm, input logic [3:0] dd,
                     input logic [3:0] dv, input logic [3:0] q,
                     input logic [3:0] r, input logic [3:0] mask);
    int c0;
    issue(dd, dv, c0);
    if (dv == 0) push(q, r, 1'b1, 4'd0, 0, c0);
    else push(q, r, 1'b0, mask, 4, c0 + 12);
    wait_done(nm);
    @(negedge clk);
  endtask

  task automatic idle_outputs(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_quo"}, quotient, 0);
    chk({nm, "_rem"}, remainder, 0);
    chk({nm, "_dbz"}, div_by_zero, 0);
    chk({nm, "_strb"}, {shift_en, sub_en, restore_en}, 0);
  endtask

  initial begin
    int c0;
    // Reset with start held and operands nonzero
    rst = 1'b1;
    start = 1'b1;
    dividend = 4'd7;
    divisor = 4'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_outputs("reset");
    rst = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_idle", busy, 0);
    end

    run("7_2", 4'd7, 4'd2, 4'd3, 4'd1, 4'b1100);
    run("15_1", 4'd15, 4'd1, 4'd15, 4'd0, 4'b0000);
    run("5_7", 4'd5, 4'd7, 4'd0, 4'd5, 4'b1111);
    run("9_0", 4'd9, 4'd0, 4'd15, 4'd9, 4'd0);
    run("9_4", 4'd9, 4'd4, 4'd2, 4'd1, 4'b1101);

    // start held high; operands change mid-operation
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd6;
    divisor = 4'd3;
    @(posedge clk);
    #1;
    c0 = cyc;
    push(4'd2, 4'd0, 1'b0, 4'b1101, 4, c0 + 12);
    push(4'd2, 4'd2, 1'b0, 4'b1101, 4, c0 + 26);
    @(negedge clk);
    dividend = 4'd8;
    divisor = 4'd3;
    wait_done("held1");
    wait_done("held2");
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("held_stop", busy, 0);

    // Reset aborts an in-flight 13/4
    issue(4'd13, 4'd4, c0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_outputs("abort");
    run("13_4", 4'd13, 4'd4, 4'd3, 4'd1, 4'b1100);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
